mult_share_arbiter: RTL and testbench



---
 rtl/mult_share_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one combinational fixed-point multiplier between NUM_REQ requesters.
// A winner is picked round-robin (or lowest index when MULT_ARB_FIXED_PRIO_EN
// is defined). Its operands are registered onto mul_a/mul_b. The multiplier
// output is captured one cycle later and returned with a one-hot done pulse.
//
// Handshake: a requester raises req with stable operands and keeps both until
// it sees its done bit. It must drop req in the cycle after done, or the level
// is taken as a fresh request. Operands are sampled only on the IDLE->CALC
// edge. Dropping req after the grant does not cancel the operation.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a_bus,
  input  logic [NUM_REQ*WIDTH-1:0] op_b_bus,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [WIDTH-1:0]         mul_out,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  int                   rank;
  int                   best_rank;

  // Winner selection from the current request vector.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    rank       = 0;
    best_rank  = 2 * NUM_REQ;
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[IDX_W'(i)] && !pick_valid) begin
        pick_idx   = IDX_W'(i);
        pick_valid = 1'b1;
      end
    end
`else
    // Rank = distance above last, so last+1 ranks 1 and last itself ranks NUM_REQ.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[IDX_W'(i)]) begin
        rank = (i > int'(last_q)) ? (i - int'(last_q)) : (i - int'(last_q) + NUM_REQ);
        if (rank < best_rank) begin
          best_rank  = rank;
          pick_idx   = IDX_W'(i);
          pick_valid = 1'b1;
        end
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> CALC on any request, then CALC -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_CALC;
      ST_CALC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values for each state.
  always_comb begin
    last_d   = last_q;
    win_d    = win_q;
    grant_d  = grant_q;
    done_d   = done_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          grant_d = ONE_HOT0 << pick_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
              mul_a_d = op_a_bus[i*WIDTH +: WIDTH];
              mul_b_d = op_b_bus[i*WIDTH +: WIDTH];
            end
          end
        end
      end
      ST_CALC: begin
        // The multiplier has had a full cycle to settle on mul_a_q/mul_b_q.
        result_d = mul_out;
        done_d   = ONE_HOT0 << win_q;
      end
      ST_DONE: begin
        done_d  = '0;
        grant_d = '0;
        last_d  = win_q;
      end
      default: begin
        done_d  = '0;
        grant_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= IDX_W'(NUM_REQ - 1);
      win_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      last_q   <= last_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios with literal expectations
// followed by randomized requesters, all checked against a timeline model.
module tb_mult_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [N*W-1:0] op_a_bus = '0;
  logic [N*W-1:0] op_b_bus = '0;
  logic [N-1:0]   grant, done;
  logic [W-1:0]   result, mul_a, mul_b, mul_out;
  logic           busy;

  int tests = 0;
  int fails = 0;

  // Fixed-point multiplier stand-in: signed 13-bit mantissas, scales add (saturate at 7).
  function automatic logic [15:0] mult(input logic [15:0] a, input logic [15:0] b);
    logic signed [12:0] x, y;
    logic signed [25:0] p;
    logic [3:0] s;
    x = a[15:3];
    y = b[15:3];
    p = x * y;
    s = {1'b0, a[2:0]} + {1'b0, b[2:0]};
    if (s > 4'd7) s = 4'd7;
    return {p[12:0], s[2:0]};
  endfunction

  assign mul_out = mult(mul_a, mul_b);

  mult_share_arbiter #(.NUM_REQ(N), .IDX_W(2), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .op_a_bus (op_a_bus),
    .op_b_bus (op_b_bus),
    .grant    (grant),
    .done     (done),
    .result   (result),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_out  (mul_out),
    .busy     (busy)
  );

  // ---------------- reference model ----------------
  // Winner rule: fixed = lowest index; round-robin = first set bit after last.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int w;
    w = -1;
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int k = N - 1; k >= 0; k--) if (r[k]) w = k;
`else
    for (int k = N; k >= 1; k--) if (r[(last + k) % N]) w = (last + k) % N;
`endif
    return w;
  endfunction

  // Timeline: m_age counts cycles since the grant (0 = free).
  int           m_age = 0;
  int           m_last = N - 1;
  int           m_win = 0;
  int           m_pick;
  logic [N-1:0] m_grant = '0, m_done = '0;
  logic [W-1:0] m_result = '0, m_a = '0, m_b = '0;

  always_comb m_pick = pick(req, m_last);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age <= 0; m_last <= N - 1; m_win <= 0;
      m_grant <= '0; m_done <= '0; m_result <= '0; m_a <= '0; m_b <= '0;
    end else begin
      case (m_age)
        0: if (m_pick >= 0) begin
          m_win   <= m_pick;
          m_grant <= N'(1) << m_pick;
          m_a     <= op_a_bus[m_pick*W +: W];
          m_b     <= op_b_bus[m_pick*W +: W];
          m_age   <= 1;
        end
        1: begin
          m_result <= mult(m_a, m_b);
          m_done   <= m_grant;
          m_age    <= 2;
        end
        default: begin
          m_done  <= '0;
          m_grant <= '0;
          m_last  <= m_win;
          m_age   <= 0;
        end
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    tests++;
    if ({grant, done, result, mul_a, mul_b, busy} !==
        {m_grant, m_done, m_result, m_a, m_b, (m_age != 0)}) begin
      fails++;
      $display("FAIL model_cmp t=%0t got g=%b d=%b r=%h a=%h b=%h busy=%b exp g=%b d=%b r=%h a=%h b=%h busy=%b",
               $time, grant, done, result, mul_a, mul_b, busy,
               m_grant, m_done, m_result, m_a, m_b, (m_age != 0));
    end
    tests++;
    if ($countones(grant) > 1 || $countones(done) > 1 || (done & ~grant) != '0) begin
      fails++;
      $display("FAIL onehot_inv t=%0t got grant=%b done=%b exp one-hot, done within grant", $time, grant, done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    op_a_bus[i*W +: W] = a;
    op_b_bus[i*W +: W] = b;
  endtask

  // Serve one request from requester i to completion (grant, done, idle).
  task automatic serve_one(input int i);
    req = N'(1) << i;
    tick();
    tick();
    req = '0;
    tick();
  endtask

  int order[4];
  int dtime[4];
  int ndone;
  logic [N-1:0] first_exp, second_exp;

  initial begin
    #1 reset = 1'b1;
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_mul", {mul_a, mul_b}, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Single operation from requester 0: 2*3 with scales 1+1 -> 6 scale 2.
    set_ops(0, 16'h0011, 16'h0019);
    req = 4'b0001;
    tick();
    check("a_grant", 32'(grant), 32'h1);
    check("a_busy", 32'(busy), 32'h1);
    check("a_mul_a", 32'(mul_a), 32'h0011);
    tick();
    check("a_done", 32'(done), 32'h1);
    check("a_result", 32'(result), 32'h0032);
    req = '0;
    tick();
    check("a_idle_busy", 32'(busy), 32'h0);
    check("a_done_clr", 32'(done), 32'h0);
    check("a_result_hold", 32'(result), 32'h0032);

    // All four requesting: round-robin from 0, done pulses 3 cycles apart.
    apply_reset();
    for (int i = 0; i < N; i++) set_ops(i, 16'($urandom), 16'($urandom));
    req = 4'b1111;
    ndone = 0;
    for (int c = 0; c < 20 && ndone < 4; c++) begin
      tick();
      if (done != '0) begin
        for (int i = 0; i < N; i++) if (done[i]) order[ndone] = i;
        dtime[ndone] = c;
        req = req & ~done;
        ndone++;
      end
    end
    check("b_done_count", 32'(ndone), 32'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      check("b_order", 32'(order[k]), 32'(k));
`else
      check("b_order", 32'(order[k]), 32'(k));
`endif
      if (k > 0) check("b_spacing", 32'(dtime[k] - dtime[k-1]), 32'd3);
    end
    req = '0;
    tick(); tick();

    // Fairness: after requester 2, request 0101 -> 0 wins; then 0 keeps asking.
    apply_reset();
    set_ops(2, 16'h0021, 16'h0011);
    set_ops(0, 16'h0019, 16'h0019);
    serve_one(2);
    req = 4'b0101;
    tick();
    check("c_wrap_grant", 32'(grant), 32'h1);
    tick(); tick(); tick();
`ifdef MULT_ARB_FIXED_PRIO_EN
    check("c_second_grant", 32'(grant), 32'h1);
`else
    check("c_second_grant", 32'(grant), 32'h4);
`endif
    req = '0;
    tick(); tick(); tick();

    // Operand change after grant does not affect the result.
    apply_reset();
    set_ops(1, 16'h0011, 16'h0019);
    req = 4'b0010;
    tick();
    check("d_grant", 32'(grant), 32'h2);
    op_a_bus[1*W +: W] = 16'h0021;
    tick();
    check("d_done", 32'(done), 32'h2);
    check("d_result", 32'(result), 32'h0032);
    req = '0;
    tick();

    // Reset during CALC discards the operation; next request served normally.
    apply_reset();
    set_ops(1, 16'h0021, 16'h0019);
    req = 4'b0010;
    tick();
    reset = 1'b1;
    #1;
    check("e_rst_grant", 32'(grant), 32'h0);
    check("e_rst_out", {result, mul_a}, 32'h0);
    check("e_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("e_no_done", 32'(done), 32'h0);
    tick();
    check("e_grant", 32'(grant), 32'h2);
    tick();
    check("e_done", 32'(done), 32'h2);
    check("e_result", 32'(result), 32'h0062);
    req = '0;
    tick();

    // First winner drops req right after grant; its done still pulses.
    apply_reset();
    set_ops(2, 16'h0011, 16'h0011);
    serve_one(2);
    set_ops(3, 16'h0019, 16'h0011);
    set_ops(1, 16'h0011, 16'h0021);
`ifdef MULT_ARB_FIXED_PRIO_EN
    first_exp = 4'b0010; second_exp = 4'b1000;
`else
    first_exp = 4'b1000; second_exp = 4'b0010;
`endif
    req = 4'b1010;
    tick();
    check("f_grant1", 32'(grant), 32'(first_exp));
    req = req & ~first_exp;
    tick();
    check("f_done1", 32'(done), 32'(first_exp));
    tick();
    check("f_idle", 32'(busy), 32'h0);
    tick();
    check("f_grant2", 32'(grant), 32'(second_exp));
    req = '0;
    tick(); tick();

    // Randomized requesters, checked every cycle by the model.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_ops(i, 16'($urandom), 16'($urandom));
          req[i] = 1'b1;
        end else if (req[i] && grant[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          op_a_bus[i*W +: W] = 16'($urandom);
        end
      end
    end
    req = '0;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
